// File: rtl/siso_layer_scheduler_pkg.sv
// Shared decoder geometry, scheduler state encoding and drain watchdog limit.
// Also used by the row-unit wrapper so both sides agree on layer/address sizing.
package siso_layer_scheduler_pkg;

  localparam int LAYERS     = 2;
  localparam int ADDRWIDTH  = 5;
  localparam int ADDRDEPTH  = 20;
  localparam int ITERBITS   = 5;
  localparam int PIPESTAGES = 11;

  localparam int LAYER_BITS  = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int WR_CNT_BITS = $clog2(ADDRDEPTH + 1);

  // Generous bound: several pipeline flushes plus a full layer of write-backs.
  localparam int WDOG_LIMIT = 4 * PIPESTAGES + ADDRDEPTH;
  localparam int WDOG_BITS  = $clog2(WDOG_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  // A zero iteration limit still runs one full iteration.
  function automatic logic [ITERBITS-1:0] iter_limit(input logic [ITERBITS-1:0] max_iter);
    return (max_iter == '0) ? ITERBITS'(1) : max_iter;
  endfunction

endpackage

// File: rtl/siso_layer_scheduler_if.sv
// Read-issue / write-back bus between the layer scheduler and one SISO row unit.
// master = scheduler (drives reads, observes write-backs); slave = row unit.
interface siso_layer_scheduler_if;
  import siso_layer_scheduler_pkg::*;

  logic [LAYER_BITS-1:0] rdlayer;
  logic [ADDRWIDTH-1:0]  rdaddress;
  logic                  rden_LLR;
  logic                  rden_E;
  logic                  wren_in;

  modport master (
    output rdlayer,
    output rdaddress,
    output rden_LLR,
    output rden_E,
    input  wren_in
  );

  modport slave (
    input  rdlayer,
    input  rdaddress,
    input  rden_LLR,
    input  rden_E,
    output wren_in
  );

endinterface

// File: rtl/siso_wb_counter.sv
// Per-layer write-back counter: saturates at ADDRDEPTH, clear wins over increment.
// Latency: count visible the cycle after the strobe; full is combinational on the count.
module siso_wb_counter
  import siso_layer_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [WR_CNT_BITS-1:0] cnt,
  output logic                   full
);

  assign full = (cnt == WR_CNT_BITS'(ADDRDEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + WR_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/siso_layer_scheduler.sv
// Layered-decoding sequencer: per layer issues ADDRDEPTH back-to-back reads, then waits for all write-backs.
// Outputs registered (one cycle after the deciding edge); the row unit has no backpressure, the drain stall is the only throttle.
module siso_layer_scheduler
  import siso_layer_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITERBITS-1:0]   max_iter,
  input  logic                  stop_req,
  siso_layer_scheduler_if.master ru,
  output logic                  busy,
  output logic                  done,
  output logic [ITERBITS-1:0]   iter_count,
  output logic                  drain_err
);

  sched_state_t           state;
  logic [ITERBITS-1:0]    lim;
  logic [ITERBITS-1:0]    iter_next;
  logic [WDOG_BITS-1:0]   wdog;
  logic [WR_CNT_BITS-1:0] wr_cnt;
  logic                   wr_full;
  logic                   wr_inc;
  logic                   wr_clr;
  logic                   wb_done;
  logic                   wdog_expired;
  logic                   drain_exit;
  logic                   last_addr;
  logic                   last_layer;

  // Write-backs are only meaningful while a layer is in flight.
  assign wr_inc       = ru.wren_in && (state == S_ISSUE || state == S_DRAIN);
  assign wb_done      = wr_full || (wr_inc && wr_cnt == WR_CNT_BITS'(ADDRDEPTH - 1));
  assign wdog_expired = (wdog == WDOG_BITS'(WDOG_LIMIT - 1));
  assign drain_exit   = (state == S_DRAIN) && (wb_done || wdog_expired);
  assign wr_clr       = (state == S_IDLE && start) || (state != S_IDLE && abort) || drain_exit;
  assign last_addr    = (ru.rdaddress == ADDRWIDTH'(ADDRDEPTH - 1));
  assign last_layer   = (ru.rdlayer == LAYER_BITS'(LAYERS - 1));
  assign iter_next    = iter_count + ITERBITS'(1);

  siso_wb_counter u_wb_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (wr_clr),
    .inc  (wr_inc),
    .cnt  (wr_cnt),
    .full (wr_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lim          <= '0;
      wdog         <= '0;
      ru.rdlayer   <= '0;
      ru.rdaddress <= '0;
      ru.rden_LLR  <= 1'b0;
      ru.rden_E    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      iter_count   <= '0;
      drain_err    <= 1'b0;
    end else if (state != S_IDLE && abort) begin
      state        <= S_IDLE;
      wdog         <= '0;
      ru.rdlayer   <= '0;
      ru.rdaddress <= '0;
      ru.rden_LLR  <= 1'b0;
      ru.rden_E    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_ISSUE;
            lim          <= iter_limit(max_iter);
            wdog         <= '0;
            iter_count   <= '0;
            drain_err    <= 1'b0;
            busy         <= 1'b1;
            ru.rdlayer   <= '0;
            ru.rdaddress <= '0;
            ru.rden_LLR  <= 1'b1;
            ru.rden_E    <= 1'b0;
          end
        end

        S_ISSUE: begin
          if (last_addr) begin
            state        <= S_DRAIN;
            wdog         <= '0;
            ru.rdaddress <= '0;
            ru.rden_LLR  <= 1'b0;
            ru.rden_E    <= 1'b0;
          end else begin
            ru.rdaddress <= ru.rdaddress + ADDRWIDTH'(1);
          end
        end

        S_DRAIN: begin
          if (drain_exit) begin
            // A watchdog exit is treated as a completed drain, only flagged.
            if (!wb_done) begin
              drain_err <= 1'b1;
            end
            if (!last_layer) begin
              state       <= S_ISSUE;
              ru.rdlayer  <= ru.rdlayer + LAYER_BITS'(1);
              ru.rden_LLR <= 1'b1;
              ru.rden_E   <= (iter_count != '0);
            end else begin
              iter_count <= iter_next;
              ru.rdlayer <= '0;
              if (iter_next == lim || stop_req) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state       <= S_ISSUE;
                ru.rden_LLR <= 1'b1;
                ru.rden_E   <= 1'b1;
              end
            end
          end else begin
            wdog <= wdog + WDOG_BITS'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Directed scoreboard bench for siso_layer_scheduler with a fixed-latency row-unit model.
// Expected reads/done pulses (cycle-exact) are queued by the stimulus and popped by the negedge monitor.
module tb_siso_layer_scheduler;
  import siso_layer_scheduler_pkg::*;

  localparam int LAT = 11;
  // Nominal layer period: 20 issue cycles + 11 drain cycles.
  localparam int LP  = 31;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic                stop_req;
  logic [ITERBITS-1:0] max_iter;
  logic                busy;
  logic                done;
  logic [ITERBITS-1:0] iter_count;
  logic                drain_err;

  siso_layer_scheduler_if bus();

  siso_layer_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .max_iter   (max_iter),
    .stop_req   (stop_req),
    .ru         (bus),
    .busy       (busy),
    .done       (done),
    .iter_count (iter_count),
    .drain_err  (drain_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int layer;
    int addr;
    int rde;
    int derr;
  } rd_exp_t;

  typedef struct {
    int cyc;
    int iter;
    int derr;
  } done_exp_t;

  int        checks   = 0;
  int        errors   = 0;
  int        cyc      = 0;
  int        rd_total = 0;
  int        done_cnt = 0;
  int        drop_at  = -1;
  int        delay_at = -1;
  rd_exp_t   exp_rd[$];
  done_exp_t exp_done[$];
  bit        wsched[int];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic exp_layer(input int t, input int layer, input int rde, input int derr, input int n);
    for (int k = 0; k < n; k++) begin
      rd_exp_t e;
      e.cyc = t + k; e.layer = layer; e.addr = k; e.rde = rde; e.derr = derr;
      exp_rd.push_back(e);
    end
  endtask

  task automatic exp_dn(input int t, input int iter, input int derr);
    done_exp_t d;
    d.cyc = t; d.iter = iter; d.derr = derr;
    exp_done.push_back(d);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + row-unit model
  always @(negedge clk) begin
    rd_exp_t   e;
    done_exp_t d;
    int        lat;
    if (!rst) begin
      if (bus.rden_LLR) begin
        if (exp_rd.size() == 0) begin
          chk("extra_read_addr", int'(bus.rdaddress), -1);
        end else begin
          e = exp_rd.pop_front();
          chk("read_cycle", cyc, e.cyc);
          chk("rdaddress", int'(bus.rdaddress), e.addr);
          chk("rdlayer", int'(bus.rdlayer), e.layer);
          chk("rden_E", int'(bus.rden_E), e.rde);
          chk("drain_err_at_read", int'(drain_err), e.derr);
          chk("busy_at_read", int'(busy), 1);
        end
      end else begin
        chk("rden_E_without_read", int'(bus.rden_E), 0);
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          chk("extra_done_iter", int'(iter_count), -1);
        end else begin
          d = exp_done.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_iter_count", int'(iter_count), d.iter);
          chk("done_drain_err", int'(drain_err), d.derr);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
    bus.wren_in = (wsched.exists(cyc) != 0);
    if (bus.wren_in) wsched.delete(cyc);
    if (bus.rden_LLR) begin
      if (rd_total != drop_at) begin
        lat = LAT + ((rd_total == delay_at) ? 30 : 0);
        wsched[cyc + lat] = 1'b1;
      end
      rd_total++;
    end
  end

  task automatic kick(input int mi, output int t0);
    @(negedge clk);
    max_iter = ITERBITS'(mi);
    start    = 1'b1;
    t0       = cyc + 1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int prev, input int limit);
    int n = 0;
    while (done_cnt == prev && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt - prev, 1);
  endtask

  task automatic finish_test(input string name);
    repeat (15) @(negedge clk);
    chk({name, "_reads_left"}, exp_rd.size(), 0);
    chk({name, "_dones_left"}, exp_done.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdlayer"},    int'(bus.rdlayer), 0);
    chk({tag, "_rdaddress"},  int'(bus.rdaddress), 0);
    chk({tag, "_rden_LLR"},   int'(bus.rden_LLR), 0);
    chk({tag, "_rden_E"},     int'(bus.rden_E), 0);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_done"},       int'(done), 0);
    chk({tag, "_iter_count"}, int'(iter_count), 0);
    chk({tag, "_drain_err"},  int'(drain_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int prev;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stop_req = 1'b0; max_iter = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal two iterations, with an ignored start while busy
    prev = done_cnt;
    kick(2, t0);
    exp_layer(t0,          0, 0, 0, 20);
    exp_layer(t0 + LP,     1, 0, 0, 20);
    exp_layer(t0 + 2 * LP, 0, 1, 0, 20);
    exp_layer(t0 + 3 * LP, 1, 1, 0, 20);
    exp_dn(t0 + 4 * LP, 2, 0);
    release_start();
    wait_until(t0 + 40);
    start = 1'b1; max_iter = ITERBITS'(9);
    @(negedge clk);
    start = 1'b0;
    wait_done(prev, 400);
    finish_test("nominal");

    // Early stop at end of iteration 1
    prev = done_cnt;
    kick(5, t0);
    exp_layer(t0,          0, 0, 0, 20);
    exp_layer(t0 + LP,     1, 0, 0, 20);
    exp_layer(t0 + 2 * LP, 0, 1, 0, 20);
    exp_layer(t0 + 3 * LP, 1, 1, 0, 20);
    exp_dn(t0 + 4 * LP, 2, 0);
    release_start();
    wait_until(t0 + 80);
    stop_req = 1'b1;
    wait_done(prev, 400);
    stop_req = 1'b0;
    finish_test("early_stop");

    // max_iter = 0 runs exactly one iteration
    prev = done_cnt;
    kick(0, t0);
    exp_layer(t0,      0, 0, 0, 20);
    exp_layer(t0 + LP, 1, 0, 0, 20);
    exp_dn(t0 + 2 * LP, 1, 0);
    release_start();
    wait_done(prev, 400);
    finish_test("max_iter_zero");

    // Last layer-0 write-back late by 30 cycles: layer 1 starts the cycle after it
    prev = done_cnt;
    delay_at = rd_total + 19;
    kick(1, t0);
    exp_layer(t0,      0, 0, 0, 20);
    exp_layer(t0 + 61, 1, 0, 0, 20);
    exp_dn(t0 + 92, 1, 0);
    release_start();
    wait_done(prev, 400);
    delay_at = -1;
    finish_test("drain_delay");

    // Dropped write-back: watchdog releases after 64 drain cycles
    prev = done_cnt;
    drop_at = rd_total + 5;
    kick(1, t0);
    exp_layer(t0,      0, 0, 0, 20);
    exp_layer(t0 + 84, 1, 0, 1, 20);
    exp_dn(t0 + 115, 1, 1);
    release_start();
    wait_done(prev, 400);
    drop_at = -1;
    finish_test("watchdog");

    // Abort in iteration 1 at address 7, then restart
    kick(2, t0);
    exp_layer(t0,          0, 0, 0, 20);
    exp_layer(t0 + LP,     1, 0, 0, 20);
    exp_layer(t0 + 2 * LP, 0, 1, 0, 8);
    release_start();
    wait_until(t0 + 69);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rden_LLR", int'(bus.rden_LLR), 0);
    chk("abort_iter_count", int'(iter_count), 1);
    repeat (20) @(negedge clk);
    finish_test("abort");
    prev = done_cnt;
    kick(1, t0);
    exp_layer(t0,      0, 0, 0, 20);
    exp_layer(t0 + LP, 1, 0, 0, 20);
    exp_dn(t0 + 2 * LP, 1, 0);
    release_start();
    chk("restart_iter_count", int'(iter_count), 0);
    wait_done(prev, 400);
    finish_test("restart");

    // Asynchronous reset during iteration 1, layer 1 drain
    kick(2, t0);
    exp_layer(t0,          0, 0, 0, 20);
    exp_layer(t0 + LP,     1, 0, 0, 20);
    exp_layer(t0 + 2 * LP, 0, 1, 0, 20);
    exp_layer(t0 + 3 * LP, 1, 1, 0, 20);
    release_start();
    wait_until(t0 + 118);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_iter_count", int'(iter_count), 1);
    chk("pre_rst_rdlayer", int'(bus.rdlayer), 1);
    chk("pre_rst_rdaddress", int'(bus.rdaddress), 0);
    chk("pre_rst_rden_LLR", int'(bus.rden_LLR), 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    finish_test("rst_mid_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
